ah_pl2ddr_sched: RTL and testbench

- Write-burst scheduler for the PL-to-DDR path.
- Watches the PL sample FIFO level and keeps the running DDR write offset inside a [addr_low, addr_high) region.
- Picks a power-of-two burst length that fits both the FIFO level and the remaining region space, then issues one command at a time to the AXI write engine and advances the offset on completion.
- Supports one-shot mode (stop and flag full) and ring mode (wrap to addr_low).

---
 rtl/ah_pl2ddr_pkg.sv | 16 +
 rtl/ah_pl2ddr_len_sel.sv | 34 +++
 rtl/ah_pl2ddr_sched.sv | 140 ++++++++++++++
 tb/tb_ah_pl2ddr_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ah_pl2ddr_pkg.sv
// Shared types and constants for the PL-to-DDR write-burst scheduler.
package ah_pl2ddr_pkg;

    localparam int BYTES_PER_BEAT  = 4;
    localparam int MAX_BURST_LIMIT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT,
        ST_UPDATE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/ah_pl2ddr_len_sel.sv
// Burst-length priority encoder: largest power of two that fits the FIFO level,
// the remaining region space and the MAX_BURST ceiling.
module ah_pl2ddr_len_sel
    import ah_pl2ddr_pkg::*;
#(
    parameter int MAX_BURST = 256
) (
    input  logic [9:0]  fifo_count,
    input  logic [31:0] space,
    output logic [8:0]  len
);

    localparam int STEPS = $clog2(MAX_BURST_LIMIT) + 1;

    logic [STEPS-1:0] fits;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_fit
            localparam int P = 1 << gi;
            assign fits[gi] = (P <= MAX_BURST)
                           && ({22'b0, fifo_count} >= 32'(P))
                           && (space >= 32'(P * BYTES_PER_BEAT));
        end
    endgenerate

    // Ascending scan: the last (largest) candidate that fits wins.
    always_comb begin
        len = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (fits[i]) len = 9'(1 << i);
        end
    end

endmodule

// File: rtl/ah_pl2ddr_sched.sv
// Write-burst scheduler: sizes and issues one DDR write burst at a time inside
// a latched [low, high) region, in one-shot or ring mode.
module ah_pl2ddr_sched
    import ah_pl2ddr_pkg::*;
#(
    parameter int MAX_BURST    = 256,
    parameter bit WRAP_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        enable,
    input  logic        wrap_en,
    input  logic [31:0] in_ddr_addr_low,
    input  logic [31:0] in_ddr_addr_high,
    input  logic [9:0]  fifo_count,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [8:0]  cmd_len,
    input  logic        burst_done,
    output logic [31:0] cur_offset,
    output logic [15:0] wrap_count,
    output logic        full,
    output logic        busy
);

    state_t      state_reg, state_next;
    logic [31:0] low_reg, low_next;
    logic [31:0] high_reg, high_next;
    logic        wrap_reg, wrap_next;
    logic [31:0] offset_reg, offset_next;
    logic [15:0] wrap_count_reg, wrap_count_next;
    logic        full_reg, full_next;
    logic [31:0] addr_reg, addr_next;
    logic [8:0]  len_reg, len_next;

    logic [31:0] region;
    logic [31:0] space;
    logic [8:0]  len_sel;

    // A degenerate region (high <= low) or an overshot offset counts as no space.
    assign region = high_reg - low_reg;
    assign space  = (high_reg > low_reg && offset_reg < region) ? (region - offset_reg) : '0;

    ah_pl2ddr_len_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_len_sel (
        .fifo_count (fifo_count),
        .space      (space),
        .len        (len_sel)
    );

    always_comb begin
        state_next      = state_reg;
        low_next        = low_reg;
        high_next       = high_reg;
        wrap_next       = wrap_reg;
        offset_next     = offset_reg;
        wrap_count_next = wrap_count_reg;
        full_next       = full_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;

        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    low_next        = in_ddr_addr_low;
                    high_next       = in_ddr_addr_high;
                    wrap_next       = wrap_en;
                    offset_next     = '0;
                    wrap_count_next = '0;
                    full_next       = 1'b0;
                    state_next      = ST_CALC;
                end
            end
            ST_CALC: begin
                if (enable && fifo_count != '0) begin
                    if (space < 32'(BYTES_PER_BEAT)) begin
                        if (wrap_reg) begin
                            offset_next = '0;
                            if (wrap_count_reg != 16'hFFFF) wrap_count_next = wrap_count_reg + 16'd1;
                        end else begin
                            full_next  = 1'b1;
                            state_next = ST_HALT;
                        end
                    end else begin
                        addr_next  = low_reg + offset_reg;
                        len_next   = len_sel;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (burst_done) state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                offset_next = offset_reg + (32'(len_reg) * 32'(BYTES_PER_BEAT));
                state_next  = ST_CALC;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            low_reg        <= '0;
            high_reg       <= '0;
            wrap_reg       <= WRAP_DEFAULT;
            offset_reg     <= '0;
            wrap_count_reg <= '0;
            full_reg       <= 1'b0;
            addr_reg       <= '0;
            len_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            low_reg        <= low_next;
            high_reg       <= high_next;
            wrap_reg       <= wrap_next;
            offset_reg     <= offset_next;
            wrap_count_reg <= wrap_count_next;
            full_reg       <= full_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
        end
    end

    assign cmd_valid  = (state_reg == ST_ISSUE);
    assign cmd_addr   = addr_reg;
    assign cmd_len    = len_reg;
    assign cur_offset = offset_reg;
    assign wrap_count = wrap_count_reg;
    assign full       = full_reg;
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_HALT);

endmodule

// File: tb/tb_ah_pl2ddr_sched.sv
// Directed self-checking bench for the PL-to-DDR burst scheduler.
module tb_ah_pl2ddr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        enable;
    logic        wrap_en;
    logic [31:0] in_ddr_addr_low;
    logic [31:0] in_ddr_addr_high;
    logic [9:0]  fifo_count;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        burst_done;
    logic [31:0] cur_offset;
    logic [15:0] wrap_count;
    logic        full;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ah_pl2ddr_sched #(
        .MAX_BURST    (256),
        .WRAP_DEFAULT (1'b0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .enable           (enable),
        .wrap_en          (wrap_en),
        .in_ddr_addr_low  (in_ddr_addr_low),
        .in_ddr_addr_high (in_ddr_addr_high),
        .fifo_count       (fifo_count),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .burst_done       (burst_done),
        .cur_offset       (cur_offset),
        .wrap_count       (wrap_count),
        .full             (full),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] lo, input logic [31:0] hi,
                           input logic wr, input logic [9:0] fc);
        rst = 1'b1;
        step();
        rst              = 1'b0;
        in_ddr_addr_low  = lo;
        in_ddr_addr_high = hi;
        wrap_en          = wr;
        fifo_count       = fc;
        enable           = 1'b1;
        start            = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !cmd_valid; i++) step();
        check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    endtask

    // Accept the pending command, then pulse burst_done 4 cycles after accept;
    // ends with the block back in CALC and the offset already advanced.
    task automatic finish_burst(input logic [9:0] new_fifo, input logic new_en);
        cmd_ready = 1'b1;
        step();
        cmd_ready  = 1'b0;
        fifo_count = new_fifo;
        enable     = new_en;
        repeat (3) step();
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        step();
    endtask

    task automatic do_burst(input string tag, input logic [31:0] exp_addr,
                            input logic [8:0] exp_len, input logic [31:0] exp_off,
                            input logic [9:0] new_fifo);
        wait_valid(tag);
        check({tag, "_addr"}, cmd_addr, exp_addr);
        check({tag, "_len"}, 32'(cmd_len), 32'(exp_len));
        check({tag, "_off"}, cur_offset, exp_off);
        finish_burst(new_fifo, 1'b1);
    endtask

    initial begin
        logic seen_valid;
        rst = 1'b1; start = 1'b0; enable = 1'b0; wrap_en = 1'b0;
        in_ddr_addr_low = '0; in_ddr_addr_high = '0; fifo_count = '0;
        cmd_ready = 1'b0; burst_done = 1'b0;
        repeat (2) step();

        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_addr", cmd_addr, 32'd0);
        check("rst_len", 32'(cmd_len), 32'd0);
        check("rst_off", cur_offset, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // One-shot 4 KiB region, fifo 300: four 256-beat bursts, then full.
        restart(32'h1000_0000, 32'h1000_1000, 1'b0, 10'd300);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++)
            do_burst($sformatf("t1_b%0d", i), 32'h1000_0000 + 32'(i) * 32'h400,
                     9'd256, 32'(i) * 32'h400, 10'd300);
        for (int i = 0; i < 10 && !full; i++) step();
        check("t1_full", 32'(full), 32'd1);
        check("t1_halt_busy", 32'(busy), 32'd0);
        check("t1_off", cur_offset, 32'h1000);

        // FIFO-limited lengths: 13 -> 8 beats, then 5 -> 4 beats.
        restart(32'h2000_0000, 32'h3000_0000, 1'b0, 10'd13);
        do_burst("t2_b0", 32'h2000_0000, 9'd8, 32'h0, 10'd5);
        do_burst("t2_b1", 32'h2000_0020, 9'd4, 32'h20, 10'd5);
        check("t2_off_after", cur_offset, 32'h30);

        // Ring region of 0x40 bytes: space-limited tail burst, then wrap.
        restart(32'h3000_0000, 32'h3000_0040, 1'b1, 10'd12);
        do_burst("t3_b0", 32'h3000_0000, 9'd8, 32'h0, 10'd4);
        do_burst("t3_b1", 32'h3000_0020, 9'd4, 32'h20, 10'd100);
        do_burst("t3_b2", 32'h3000_0030, 9'd4, 32'h30, 10'd100);
        wait_valid("t3_wrap");
        check("t3_wrap_cnt", 32'(wrap_count), 32'd1);
        check("t3_wrap_off", cur_offset, 32'd0);
        check("t3_wrap_addr", cmd_addr, 32'h3000_0000);
        check("t3_wrap_len", 32'(cmd_len), 32'd16);

        // Backpressure: cmd_ready low 10 cycles, stray burst_done ignored.
        for (int i = 0; i < 10; i++) begin
            burst_done = (i == 3);
            step();
            check($sformatf("t4_hold%0d_valid", i), 32'(cmd_valid), 32'd1);
            check($sformatf("t4_hold%0d_addr", i), cmd_addr, 32'h3000_0000);
            check($sformatf("t4_hold%0d_len", i), 32'(cmd_len), 32'd16);
            check($sformatf("t4_hold%0d_off", i), cur_offset, 32'd0);
        end
        burst_done = 1'b0;

        // Enable dropped during WAIT: burst completes, then the block idles in CALC.
        finish_burst(10'd100, 1'b0);
        check("t5_off", cur_offset, 32'h40);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_valid) seen_valid = 1'b1;
        end
        check("t5_no_cmd", 32'(seen_valid), 32'd0);
        check("t5_no_wrap", 32'(wrap_count), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        wait_valid("t5_resume");
        check("t5_resume_cnt", 32'(wrap_count), 32'd2);
        check("t5_resume_addr", cmd_addr, 32'h3000_0000);

        // Reset while in WAIT clears everything.
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 32'(cmd_valid), 32'd0);
        check("t6_addr", cmd_addr, 32'd0);
        check("t6_len", 32'(cmd_len), 32'd0);
        check("t6_off", cur_offset, 32'd0);
        check("t6_wrap", 32'(wrap_count), 32'd0);
        check("t6_full", 32'(full), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        in_ddr_addr_low  = 32'h4000_0000;
        in_ddr_addr_high = 32'h4000_1000;
        wrap_en          = 1'b0;
        fifo_count       = 10'd1;
        start            = 1'b1;
        step();
        start = 1'b0;
        do_burst("t6_restart", 32'h4000_0000, 9'd1, 32'd0, 10'd1);

        // Degenerate region in one-shot mode: straight to HALT, never issues.
        restart(32'h0000_0100, 32'h0000_0100, 1'b0, 10'd50);
        seen_valid = 1'b0;
        for (int i = 0; i < 10 && !full; i++) begin
            if (cmd_valid) seen_valid = 1'b1;
            step();
        end
        check("t7_full", 32'(full), 32'd1);
        check("t7_no_cmd", 32'(seen_valid), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
